pool_window_sequencer: RTL and testbench
========================================

# pool_window_sequencer

Sequential max-pooling engine for the kernel-pooling datapath: captures one AX×AY frame of DEPTH-bit elements from a valid/ready stream, then walks every KX×KY window (stride 1) and emits one maximum per window on a valid/ready output. Output ordering and element indexing match the combinational `Kernel_Pooler`, so results are drop-in comparable. Area is traded for latency: one comparator, one frame buffer.

## Interface
- DEPTH, 8, element width in bits
- KX, 3, window width (x)
- KY, 3, window height (y)
- AX, 8, frame width (x)
- AY, 8, frame height (y)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins frame load when idle
- in_valid  in  1  input element valid
- in_ready  out  1  high only in LOAD
- in_data  in  DEPTH  element; stream order x-fastest (index = y*AX + x)
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accepts
- out_data  out  DEPTH  window maximum
- out_last  out  1  high with final window's result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last result accepted

## Operation
- States: IDLE, LOAD, SCAN, OUT.
- IDLE: start -> LOAD, clear counters. start outside IDLE ignored.
- LOAD: each in_valid&&in_ready writes buffer[y*AX+x]; after AX*AY writes -> SCAN with window (i=0,j=0).
- SCAN: one element per cycle, ky outer, kx inner over x=i+kx, y=j+ky; first element loads accumulator, rest compare-and-keep-larger (ties keep accumulator). After KX*KY elements -> OUT.
- OUT: out_valid=1, out_data=accumulator, stable until out_ready. On handshake: advance j; at j=AY-KY wrap j=0, advance i; after i=AX-KX,j=AY-KY -> IDLE with done pulse, else -> SCAN.
- Output order: result n = i*(AY-KY+1)+j, i = x origin, j = y origin; total (AX-KX+1)*(AY-KY+1).
- Comparison unsigned (see Configuration). No arithmetic beyond compare; counters sized $clog2 of their range +1.
- Frame buffer not cleared by reset; contents undefined until fully loaded.

## Timing
- Reset (async assert, sync release): state IDLE; in_ready, out_valid, out_data, out_last, busy, done all 0; counters 0.
- start sampled cycle t -> in_ready=1, busy=1 at t+1.
- Last element accepted cycle t -> SCAN at t+1; out_valid at t+1+KX*KY (defaults: 9 cycles).
- Per window with out_ready tied high: KX*KY+1 cycles.
- out_valid low during SCAN; no back-pressure on SCAN.
- done asserted the cycle after final handshake, busy drops same cycle.
- in_valid with in_ready low: ignored, not buffered.
- Reset mid-LOAD/SCAN/OUT: immediate return to IDLE, partial result discarded; new frame requires start.

## Configuration
- POOL_SEQ_SIGNED_EN defined: in_data/out_data interpreted two's complement, comparator signed.
- Undefined: unsigned comparison (default, matches `Kernel_Pooler`).
- Affects only the comparator; interface and timing unchanged.

## Structure
- Shared package `pool_pkg`: state enum (IDLE/LOAD/SCAN/OUT), helper function for output count (AX-KX+1)*(AY-KY+1), index function y*AX+x.
- One sub-module: `pool_max_acc` (accumulator register + comparator, load/compare enable, POOL_SEQ_SIGNED_EN inside).
- Frame buffer as register array in top level.

## Test plan
- Ramp frame in_data=k (k=0..63), out_ready=1 -> 36 results, result(i,j)=(j+2)*8+(i+2): first 18, second 26, last 63 with out_last; done one cycle later.
- Back-pressure: out_ready low 5 cycles on result 0 -> out_valid, out_data=18 held stable; no result skipped or duplicated.
- Input gaps: in_valid toggled every other cycle -> identical 36 results; in_valid while IDLE/SCAN ignored.
- Sign: frame all 8'h01 except element 0 = 8'hFF -> window(0,0) gives 255 unsigned; with POOL_SEQ_SIGNED_EN gives 1.
- Reset mid-SCAN of window 3 -> next cycle all outputs 0, IDLE; fresh start + ramp reproduces scenario 1 exactly.
- start pulsed during OUT -> ignored; result sequence unchanged.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and index helpers for the sequential max-pooling engine.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        OUT
    } state_t;

    function automatic int out_count(int ax, int ay, int kx, int ky);
        return (ax - kx + 1) * (ay - ky + 1);
    endfunction

    function automatic int elem_index(int x, int y, int ax);
        return y * ax + x;
    endfunction

endpackage

// File: rtl/pool_max_acc.sv
// Running-maximum accumulator: load takes the first element, later elements replace it only if larger.
// POOL_SEQ_SIGNED_EN selects a two's-complement comparator instead of unsigned.
module pool_max_acc #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DEPTH-1:0] d,
    output logic [DEPTH-1:0] q
);

    logic greater;

`ifdef POOL_SEQ_SIGNED_EN
    assign greater = $signed(d) > $signed(q);
`else
    assign greater = d > q;
`endif

    // Ties keep the held value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en && (load || greater))
            q <= d;
    end

endmodule

// File: rtl/pool_window_sequencer.sv
// Buffers one AX x AY frame, then emits the max of every KX x KY window (stride 1), y-origin fastest.
// Build with POOL_SEQ_SIGNED_EN defined for a signed comparator.
module pool_window_sequencer
    import pool_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int KX    = 3,
    parameter int KY    = 3,
    parameter int AX    = 8,
    parameter int AY    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEPTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEPTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int NELEM = AX * AY;
    localparam int NOUT  = out_count(AX, AY, KX, KY);
    localparam int AW    = $clog2(NELEM);
    localparam int XW    = $clog2(AX) + 1;
    localparam int YW    = $clog2(AY) + 1;
    localparam int KXW   = $clog2(KX) + 1;
    localparam int KYW   = $clog2(KY) + 1;
    localparam int RW    = $clog2(NOUT) + 1;

    state_t         state;
    logic [XW-1:0]  lx, wi;
    logic [YW-1:0]  ly, wj;
    logic [KXW-1:0] kx;
    logic [KYW-1:0] ky;
    logic [RW-1:0]  res_cnt;

    logic [DEPTH-1:0] frame [NELEM];
    logic [AW-1:0]    wr_addr, rd_addr;
    logic             load_fire, scan_first;

    assign load_fire  = in_valid && in_ready;
    assign scan_first = (kx == '0) && (ky == '0);
    assign wr_addr    = AW'(elem_index(int'(lx), int'(ly), AX));
    assign rd_addr    = AW'(elem_index(int'(wi) + int'(kx), int'(wj) + int'(ky), AX));

    // Frame storage carries no reset; it is fully rewritten before every scan.
    always_ff @(posedge clk) begin
        if (load_fire)
            frame[wr_addr] <= in_data;
    end

    pool_max_acc #(.DEPTH(DEPTH)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == SCAN),
        .load  (scan_first),
        .d     (frame[rd_addr]),
        .q     (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lx        <= '0;
            ly        <= '0;
            wi        <= '0;
            wj        <= '0;
            kx        <= '0;
            ky        <= '0;
            res_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        lx       <= '0;
                        ly       <= '0;
                        wi       <= '0;
                        wj       <= '0;
                        kx       <= '0;
                        ky       <= '0;
                        res_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        if (lx == XW'(AX - 1)) begin
                            lx <= '0;
                            if (ly == YW'(AY - 1)) begin
                                ly       <= '0;
                                in_ready <= 1'b0;
                                state    <= SCAN;
                            end else begin
                                ly <= ly + 1'b1;
                            end
                        end else begin
                            lx <= lx + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // ky outer, kx inner; the final element lands in the accumulator on this edge
                    if (kx == KXW'(KX - 1)) begin
                        kx <= '0;
                        if (ky == KYW'(KY - 1)) begin
                            ky        <= '0;
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_last  <= (res_cnt == RW'(NOUT - 1));
                        end else begin
                            ky <= ky + 1'b1;
                        end
                    end else begin
                        kx <= kx + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        res_cnt   <= res_cnt + 1'b1;
                        if (res_cnt == RW'(NOUT - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= SCAN;
                            if (wj == YW'(AY - KY)) begin
                                wj <= '0;
                                wi <= wi + 1'b1;
                            end else begin
                                wj <= wj + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Directed bench for pool_window_sequencer with default 8x8 frame and 3x3 windows.
module tb_pool_window_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, busy, done;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_q [64];
    logic [7:0] res_data [36];
    logic       res_last [36];
    int         res_cyc [36];
    int         hold_bad;

`ifdef POOL_SEQ_SIGNED_EN
    localparam logic [7:0] SIGN_EXP = 8'h01;
`else
    localparam logic [7:0] SIGN_EXP = 8'hFF;
`endif

    always #5 clk = ~clk;

    pool_window_sequencer #(.DEPTH(8), .KX(3), .KY(3), .AX(8), .AY(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Window (i,j) of a ramp frame peaks at its bottom-right element (i+2, j+2).
    function automatic logic [7:0] ramp_exp(int n);
        return 8'(((n % 6) + 2) * 8 + (n / 6) + 2);
    endfunction

    task automatic ramp_frame();
        for (int k = 0; k < 64; k++) frame_q[k] = 8'(k);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic load_frame(input bit gaps, output int got);
        int  cyc;
        bit  tog;
        bit  fire;
        got = 0; cyc = 0; tog = 1'b0;
        while (got < 64 && cyc < 1000) begin
            @(negedge clk);
            in_valid = gaps ? tog : 1'b1;
            tog      = ~tog;
            in_data  = frame_q[got];
            fire     = in_valid && in_ready;
            @(posedge clk);
            if (fire) got++;
            cyc++;
        end
        @(negedge clk) in_valid = 1'b0;
    endtask

    task automatic collect(input int max_n, input int stall, input int start_n, output int n);
        int         stall_left, cyc;
        logic [7:0] held;
        n = 0; stall_left = stall; cyc = 0; hold_bad = 0; held = 8'h00;
        while (n < max_n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            out_ready = 1'b1;
            if (out_valid) begin
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    if (stall_left == stall) held = out_data;
                    else if (out_data !== held) hold_bad++;
                    stall_left--;
                end else begin
                    if (stall > 0 && n == 0 && out_data !== held) hold_bad++;
                    res_data[n] = out_data;
                    res_last[n] = out_last;
                    res_cyc[n]  = cyc;
                    if (n == start_n) start = 1'b1;
                    n++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%b in_ready=%b exp 0 0", busy, in_ready); end
    endtask

    task automatic test_ramp();
        int got, n, nlast;
        ramp_frame();
        do_start();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_latency got in_ready=%b busy=%b exp 1 1", in_ready, busy); end
        load_frame(1'b0, got);
        checks++; if (got !== 64) begin errors++; $display("FAIL ramp_load_count got %0d exp 64", got); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL scan_entry got in_ready=%b busy=%b out_valid=%b exp 0 1 0", in_ready, busy, out_valid); end
        collect(36, 0, -1, n);
        checks++; if (n !== 36) begin errors++; $display("FAIL ramp_result_count got %0d exp 36", n); end
        nlast = 0;
        for (int r = 0; r < n; r++) begin
            checks++; if (res_data[r] !== ramp_exp(r)) begin errors++; $display("FAIL ramp_result n=%0d got %0d exp %0d", r, res_data[r], ramp_exp(r)); end
            if (res_last[r] === 1'b1) nlast++;
        end
        checks++; if (res_last[35] !== 1'b1 || nlast !== 1) begin errors++; $display("FAIL ramp_out_last got last35=%b count=%0d exp 1 1", res_last[35], nlast); end
        checks++; if (res_cyc[0] !== 9) begin errors++; $display("FAIL first_result_latency got %0d exp 9", res_cyc[0]); end
        checks++; if (res_cyc[1] - res_cyc[0] !== 10) begin errors++; $display("FAIL window_period got %0d exp 10", res_cyc[1] - res_cyc[0]); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ramp_done got done=%b busy=%b out_valid=%b exp 1 0 0", done, busy, out_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b exp 0", done); end
    endtask

    task automatic test_back_pressure();
        int got, n;
        ramp_frame();
        do_start();
        load_frame(1'b0, got);
        collect(36, 5, -1, n);
        checks++; if (n !== 36) begin errors++; $display("FAIL bp_result_count got %0d exp 36", n); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold_stable got %0d changes exp 0", hold_bad); end
        checks++; if (res_cyc[0] !== 14) begin errors++; $display("FAIL bp_accept_cycle got %0d exp 14", res_cyc[0]); end
        for (int r = 0; r < n; r++) begin
            checks++; if (res_data[r] !== ramp_exp(r)) begin errors++; $display("FAIL bp_result n=%0d got %0d exp %0d", r, res_data[r], ramp_exp(r)); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done); end
    endtask

    task automatic test_input_gaps();
        int got, n;
        ramp_frame();
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ignores_input got in_ready=%b busy=%b exp 0 0", in_ready, busy); end
        in_valid = 1'b0;
        do_start();
        load_frame(1'b1, got);
        checks++; if (got !== 64) begin errors++; $display("FAIL gap_load_count got %0d exp 64", got); end
        in_valid = 1'b1; in_data = 8'hEE;
        collect(36, 0, -1, n);
        checks++; if (n !== 36) begin errors++; $display("FAIL gap_result_count got %0d exp 36", n); end
        for (int r = 0; r < n; r++) begin
            checks++; if (res_data[r] !== ramp_exp(r)) begin errors++; $display("FAIL gap_result n=%0d got %0d exp %0d", r, res_data[r], ramp_exp(r)); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got %b exp 1", done); end
        in_valid = 1'b0;
    endtask

    task automatic test_sign();
        int got, n;
        for (int k = 0; k < 64; k++) frame_q[k] = 8'h01;
        frame_q[0] = 8'hFF;
        do_start();
        load_frame(1'b0, got);
        collect(36, 0, -1, n);
        checks++; if (n !== 36) begin errors++; $display("FAIL sign_result_count got %0d exp 36", n); end
        checks++; if (res_data[0] !== SIGN_EXP) begin errors++; $display("FAIL sign_window0 got %0d exp %0d", res_data[0], SIGN_EXP); end
        checks++; if (res_data[1] !== 8'h01) begin errors++; $display("FAIL sign_window1 got %0d exp 1", res_data[1]); end
        checks++; if (res_data[6] !== 8'h01) begin errors++; $display("FAIL sign_window6 got %0d exp 1", res_data[6]); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sign_done got %b exp 1", done); end
    endtask

    task automatic test_reset_mid_scan();
        int got, n;
        ramp_frame();
        do_start();
        load_frame(1'b0, got);
        collect(3, 0, -1, n);
        checks++; if (n !== 3 || res_data[2] !== ramp_exp(2)) begin errors++; $display("FAIL pre_reset_results got n=%0d r2=%0d exp 3 %0d", n, res_data[2], ramp_exp(2)); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL in_scan_w3 got busy=%b out_valid=%b exp 1 0", busy, out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_data !== 8'h00) begin errors++; $display("FAIL mid_reset_outputs got flags=%b data=%0d exp 0 0", {in_ready, out_valid, out_last, busy, done}, out_data); end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stays_idle_after_reset got busy=%b out_valid=%b exp 0 0", busy, out_valid); end
        do_start();
        load_frame(1'b0, got);
        collect(36, 0, -1, n);
        checks++; if (n !== 36) begin errors++; $display("FAIL rerun_result_count got %0d exp 36", n); end
        for (int r = 0; r < n; r++) begin
            checks++; if (res_data[r] !== ramp_exp(r)) begin errors++; $display("FAIL rerun_result n=%0d got %0d exp %0d", r, res_data[r], ramp_exp(r)); end
        end
        checks++; if (res_cyc[0] !== 9 || res_last[35] !== 1'b1) begin errors++; $display("FAIL rerun_timing got cyc0=%0d last=%b exp 9 1", res_cyc[0], res_last[35]); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rerun_done got %b exp 1", done); end
    endtask

    task automatic test_start_during_out();
        int got, n;
        ramp_frame();
        do_start();
        load_frame(1'b0, got);
        collect(36, 0, 10, n);
        checks++; if (n !== 36) begin errors++; $display("FAIL sout_result_count got %0d exp 36", n); end
        for (int r = 0; r < n; r++) begin
            checks++; if (res_data[r] !== ramp_exp(r)) begin errors++; $display("FAIL sout_result n=%0d got %0d exp %0d", r, res_data[r], ramp_exp(r)); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sout_done got done=%b busy=%b exp 1 0", done, busy); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL sout_no_restart got busy=%b in_ready=%b exp 0 0", busy, in_ready); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_pressure();
        test_input_gaps();
        test_sign();
        test_reset_mid_scan();
        test_start_during_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
